wb_trace_buffer: RTL and testbench

- Sits downstream of the MIPS pipeline processor's write-back stage.
- Captures every committed register write (destination register, write data, cycle stamp) into a FIFO.
- Counts hazard-stall cycles and dropped events.
- Lets the bench or debug logic drain the retirement trace through a valid/ready port, with no dependence on $fwrite dumps.

---
 rtl/wb_trace_buffer.sv | 130 +++++++++++++
 tb/tb_wb_trace_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: retirement trace capture downstream of the MIPS write-back stage.
// Every committed register write (non-$zero destination) is stamped with a free-running
// cycle counter and queued in a show-ahead FIFO. The FIFO is drained through a
// valid/ready port. Hazard stall cycles and dropped events are counted.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   enable                           capture / counting enable
//   PIPE_MEMWB_OUT_CSignal_RegWrite  write-back RegWrite
//   PIPE_MEMWB_RegDstOutput          write-back destination register
//   memtoRegOutput                   write-back data
//   PCWrite                          hazard unit PC write enable (0 = stall)
//   trace_ready                      consumer accepts head entry
//   trace_valid                      head entry present (FIFO non-empty)
//   trace_cycle/reg/data             head entry fields
//   count                            occupancy 0..DEPTH
//   overflow                         sticky drop flag
//   drop_count                       dropped events, saturating
//   stall_count                      stall cycles, saturating
module wb_trace_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned CYCLE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               PIPE_MEMWB_OUT_CSignal_RegWrite,
    input  logic [4:0]         PIPE_MEMWB_RegDstOutput,
    input  logic [31:0]        memtoRegOutput,
    input  logic               PCWrite,
    input  logic               trace_ready,
    output logic               trace_valid,
    output logic [CYCLE_W-1:0] trace_cycle,
    output logic [4:0]         trace_reg,
    output logic [31:0]        trace_data,
    output logic [ADDR_W:0]    count,
    output logic               overflow,
    output logic [7:0]         drop_count,
    output logic [15:0]        stall_count
);

    localparam int unsigned COUNT_W = ADDR_W + 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);
    localparam logic [7:0]  DROP_MAX  = 8'hFF;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [4:0]         regNum;
        logic [31:0]        data;
    } traceEntry_t;

    traceEntry_t        mem [DEPTH];
    traceEntry_t        headEntry;
    logic [ADDR_W-1:0]  wrPtr;
    logic [ADDR_W-1:0]  rdPtr;
    logic [CYCLE_W-1:0] cycleCnt;

    logic push;
    logic pop;
    logic full;
    logic doWrite;
    logic drop;

    // Capture / drain qualification; a pop on a full FIFO frees the slot for the push.
    always_comb begin
        push    = enable & PIPE_MEMWB_OUT_CSignal_RegWrite & (PIPE_MEMWB_RegDstOutput != 5'd0);
        pop     = trace_valid & trace_ready;
        full    = (count == FULL_COUNT);
        doWrite = push & (~full | pop);
        drop    = push & full & ~pop;
    end

    // Show-ahead head presentation straight from storage.
    always_comb begin
        headEntry   = mem[rdPtr];
        trace_valid = (count != '0);
        trace_cycle = headEntry.cycle;
        trace_reg   = headEntry.regNum;
        trace_data  = headEntry.data;
    end

    // Storage, pointers, occupancy and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wrPtr       <= '0;
            rdPtr       <= '0;
            cycleCnt    <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            stall_count <= '0;
        end else begin
            if (enable) begin
                cycleCnt <= cycleCnt + CYCLE_W'(1);
            end

            if (doWrite) begin
                mem[wrPtr] <= '{cycle: cycleCnt, regNum: PIPE_MEMWB_RegDstOutput, data: memtoRegOutput};
                wrPtr      <= wrPtr + ADDR_W'(1);
            end

            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end

            if (doWrite && !pop) begin
                count <= count + COUNT_W'(1);
            end else if (!doWrite && pop) begin
                count <= count - COUNT_W'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            if (enable && !PCWrite && (stall_count != STALL_MAX)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        regWrite;
    logic [4:0]  regDst;
    logic [31:0] wbData;
    logic        pcWrite;
    logic        traceReady;
    logic        traceValid;
    logic [15:0] traceCycle;
    logic [4:0]  traceReg;
    logic [31:0] traceData;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  dropCount;
    logic [15:0] stallCount;

    wb_trace_buffer #(.DEPTH(16), .ADDR_W(4), .CYCLE_W(16)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .enable                          (enable),
        .PIPE_MEMWB_OUT_CSignal_RegWrite (regWrite),
        .PIPE_MEMWB_RegDstOutput         (regDst),
        .memtoRegOutput                  (wbData),
        .PCWrite                         (pcWrite),
        .trace_ready                     (traceReady),
        .trace_valid                     (traceValid),
        .trace_cycle                     (traceCycle),
        .trace_reg                       (traceReg),
        .trace_data                      (traceData),
        .count                           (count),
        .overflow                        (overflow),
        .drop_count                      (dropCount),
        .stall_count                     (stallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cyc;
        logic [4:0]  rg;
        logic [31:0] dat;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] mCycle;
    logic        mOverflow;
    int          mDrop;
    int          mStall;
    logic        armed;
    int          errors;
    int          checks;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare DUT state with the model, apply the model transition, advance.
    task automatic tick();
        ent_t e;
        int   sizeBefore;
        logic popped;
        @(negedge clk);
        if (armed) begin
            check("valid", 32'(traceValid), 32'(sb.size() != 0));
            check("count", 32'(count), 32'(sb.size()));
            check("overflow", 32'(overflow), 32'(mOverflow));
            check("drop_count", 32'(dropCount), 32'(mDrop));
            check("stall_count", 32'(stallCount), 32'(mStall));
        end
        if (reset) begin
            sb.delete();
            mCycle    = '0;
            mOverflow = 1'b0;
            mDrop     = 0;
            mStall    = 0;
            armed     = 1'b1;
        end else begin
            sizeBefore = sb.size();
            popped     = 1'b0;
            if (sizeBefore != 0 && traceReady) begin
                e      = sb.pop_front();
                popped = 1'b1;
                check("head_cycle", 32'(traceCycle), 32'(e.cyc));
                check("head_reg", 32'(traceReg), 32'(e.rg));
                check("head_data", traceData, e.dat);
            end
            if (enable && regWrite && regDst != 5'd0) begin
                if (sizeBefore == int'(DEPTH) && !popped) begin
                    mOverflow = 1'b1;
                    if (mDrop < 255) mDrop++;
                end else begin
                    sb.push_back('{cyc: mCycle, rg: regDst, dat: wbData});
                end
            end
            if (enable && !pcWrite && mStall < 65535) mStall++;
            if (enable) mCycle = mCycle + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pushReg(input logic [4:0] r, input logic [31:0] d, input logic rdy);
        regWrite   = 1'b1;
        regDst     = r;
        wbData     = d;
        traceReady = rdy;
        tick();
        regWrite   = 1'b0;
        traceReady = 1'b0;
    endtask

    task automatic drain(input int n);
        traceReady = 1'b1;
        for (int i = 0; i < n; i++) tick();
        traceReady = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; armed = 1'b0;
        mCycle = '0; mOverflow = 1'b0; mDrop = 0; mStall = 0;
        reset = 1'b1; enable = 1'b0; regWrite = 1'b0; regDst = '0;
        wbData = '0; pcWrite = 1'b1; traceReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(traceValid), 32'd0);
        check("rst_cycle", 32'(traceCycle), 32'd0);
        check("rst_reg", 32'(traceReg), 32'd0);
        check("rst_data", traceData, 32'd0);

        // Single capture at cycle 3.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        pushReg(5'd8, 32'h0000_002A, 1'b0);
        check("cap_valid", 32'(traceValid), 32'd1);
        check("cap_reg", 32'(traceReg), 32'd8);
        check("cap_data", traceData, 32'h2A);
        check("cap_cycle", 32'(traceCycle), 32'd3);
        check("cap_count", 32'(count), 32'd1);
        drain(1);
        check("cap_drained", 32'(traceValid), 32'd0);

        // $zero filter, then disabled writes, then an enabled write to check the frozen stamp.
        for (int i = 0; i < 4; i++) pushReg(5'd0, 32'hDEAD_0000 + 32'(i), 1'b0);
        check("zero_count", 32'(count), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pushReg(5'd9, 32'h1234_5678, 1'b0);
        check("dis_count", 32'(count), 32'd0);
        enable = 1'b1;
        pushReg(5'd9, 32'hCAFE_0009, 1'b0);
        check("frozen_stamp", 32'(traceCycle), 32'(mCycle - 16'd1));
        drain(1);

        // Fill and overflow.
        for (int i = 1; i <= 18; i++) pushReg(5'(i), 32'hA000_0000 + 32'(i), 1'b0);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_drop", 32'(dropCount), 32'd2);
        drain(16);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 16; i++) pushReg(5'(i), 32'hB000_0000 + 32'(i), 1'b0);
        pushReg(5'd20, 32'hB000_0014, 1'b1);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_drop", 32'(dropCount), 32'd2);
        drain(14);
        check("reg20_pos", 32'(traceReg), 32'd16);
        drain(1);
        check("reg20_head", 32'(traceReg), 32'd20);
        drain(1);

        // Stall counting and drop saturation.
        pcWrite = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        pcWrite = 1'b1;
        check("stall5", 32'(stallCount), 32'd5);
        for (int i = 1; i <= 16; i++) pushReg(5'(i), 32'hC000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 300; i++) pushReg(5'($urandom_range(1, 31)), $urandom, 1'b0);
        check("drop_sat", 32'(dropCount), 32'd255);

        // Reset mid-operation.
        drain(9);
        check("pre_rst_count", 32'(count), 32'd7);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(traceValid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_drop", 32'(dropCount), 32'd0);
        check("mid_rst_stall", 32'(stallCount), 32'd0);
        check("mid_rst_reg", 32'(traceReg), 32'd0);
        pushReg(5'd3, 32'h0000_0055, 1'b0);
        check("post_rst_cycle", 32'(traceCycle), 32'd0);
        check("post_rst_reg", 32'(traceReg), 32'd3);
        drain(1);
        tick();
        check("end_count", 32'(count), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
